// File: rtl/aes_pkg.sv
// AES constants, FSM encoding and the four round primitives shared by the cipher core.
// Byte order follows FIPS-197: byte 0 is bits [127:120]; column c holds bytes 4c..4c+3.
package aes_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] add_round_key(input logic [BLOCK_W-1:0] s,
                                                         input logic [BLOCK_W-1:0] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round, purely combinational (zero latency, no flow control).
// MixColumns is bypassed when final_i is set.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] round_key_i,
    input  logic               final_i,
    output logic [BLOCK_W-1:0] state_o
);

    logic [BLOCK_W-1:0] shifted;
    logic [BLOCK_W-1:0] mixed;

    assign shifted = shift_rows(sub_bytes(state_i));
    assign mixed   = final_i ? shifted : mix_columns(shifted);
    assign state_o = add_round_key(mixed, round_key_i);

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryptor, one round per clock; out_valid rises NR edges after accept.
// Single block in flight: in_ready is low until the ciphertext is taken; out_ready low holds the result.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter  int NK = 4,
    localparam int NR = nr_of(NK),
    localparam int KW = 128 * (NR + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_state,
    input  logic [KW-1:0]      w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_state,
    output logic               busy
);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_cipher_iter: NK must be 4, 6 or 8");
    end

    localparam logic [3:0] NR_L = 4'(NR);

    state_e             fsm_q;
    logic [3:0]         rnd_q;
    logic [BLOCK_W-1:0] st_q;
    logic [KW-1:0]      w_q;
    logic [BLOCK_W-1:0] out_state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [3:0]         key_sel_d;
    logic [BLOCK_W-1:0] round_key_d;
    logic               final_d;
    logic [BLOCK_W-1:0] st_d;

    // rnd_q sits at NR+1 while in DONE; clamp so the key select never leaves the schedule.
    assign key_sel_d   = (rnd_q > NR_L) ? NR_L : rnd_q;
    assign round_key_d = w_q[{key_sel_d, 7'd0} +: BLOCK_W];
    assign final_d     = (rnd_q == NR_L);

    aes_round u_round (
        .state_i    (st_q),
        .round_key_i(round_key_d),
        .final_i    (final_d),
        .state_o    (st_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            rnd_q       <= 4'd0;
            st_q        <= '0;
            w_q         <= '0;
            out_state_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        w_q        <= w;
                        st_q       <= in_state ^ w[BLOCK_W-1:0];
                        rnd_q      <= 4'd1;
                        fsm_q      <= ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ROUND: begin
                    rnd_q <= rnd_q + 4'd1;
                    if (final_d) begin
                        out_state_q <= st_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        st_q <= st_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter at NK=4/6/8: software AES model plus FIPS-197 vectors.
module tb_aes_cipher_iter;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    iv;
    logic [2:0]    ord;
    logic [127:0]  ist [3];
    logic [1919:0] wv  [3];
    wire  [2:0]    irdy;
    wire  [2:0]    ov;
    wire  [2:0]    bsy;
    wire  [127:0]  ost [3];

    int   errors = 0;
    int   checks = 0;
    logic [7:0] sb [256];

    bit           started = 1'b0;
    int           edge_cnt = 0;
    bit           pend     [3];
    logic [127:0] exp_ct   [3];
    logic [127:0] last_ct  [3];
    int           acc_edge [3];
    int           xfers    [3];

    always #5 clk = ~clk;

    aes_cipher_iter #(.NK(4)) u_nk4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_state(ist[0]),
        .w(wv[0][1407:0]), .out_valid(ov[0]), .out_ready(ord[0]), .out_state(ost[0]), .busy(bsy[0]));
    aes_cipher_iter #(.NK(6)) u_nk6 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_state(ist[1]),
        .w(wv[1][1663:0]), .out_valid(ov[1]), .out_ready(ord[1]), .out_state(ost[1]), .busy(bsy[1]));
    aes_cipher_iter #(.NK(8)) u_nk8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_state(ist[2]),
        .w(wv[2][1919:0]), .out_valid(ov[2]), .out_ready(ord[2]), .out_state(ost[2]), .busy(bsy[2]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int nr_i(input int i);
        return 10 + 2 * i;
    endfunction

    // General GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [255:0] fips_key(input int nk);
        logic [255:0] k;
        k = '0;
        for (int b = 0; b < 4 * nk; b++) k[255-8*b -: 8] = 8'(b);
        return k;
    endfunction

    function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nk);
        logic [31:0]   kw [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int            total;
        total = 4 * (nk + 7);
        rc    = 8'h01;
        ks    = '0;
        for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = kw[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            kw[i] = kw[i-nk] ^ t;
        end
        for (int r = 0; r <= nk + 6; r++)
            ks[128*r +: 128] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
        return ks;
    endfunction

    // Byte-matrix AES: s[4c+row] is row 'row' of column c.
    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [1919:0] ks,
                                               input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   acc;
        logic [127:0] res;
        int           coef [4];
        coef = '{2, 3, 1, 1};
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < nr) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++)
                            acc = acc ^ gmul(8'(coef[(k-row+4)%4]), s[4*c+k]);
                        t[4*c+row] = acc;
                    end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*r + 127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Transaction monitor: updates the expected-state model from the handshakes at each edge.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst === 1'b1) begin
            started = 1'b1;
            for (int i = 0; i < 3; i++) begin
                pend[i]    = 1'b0;
                last_ct[i] = '0;
            end
        end else if (started) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && ord[i] && pend[i]) begin
                    last_ct[i] = exp_ct[i];
                    pend[i]    = 1'b0;
                    xfers[i]++;
                end
                if (iv[i] && irdy[i]) begin
                    chki($sformatf("nk%0d_single_accept", 4 + 2*i), int'(pend[i]), 0);
                    exp_ct[i]   = aes_model(ist[i], wv[i], nr_i(i));
                    pend[i]     = 1'b1;
                    acc_edge[i] = edge_cnt;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (started && rst === 1'b0) begin
            for (int i = 0; i < 3; i++) begin
                bit eov;
                eov = pend[i] && (edge_cnt - acc_edge[i] >= nr_i(i));
                chki($sformatf("nk%0d_out_valid", 4 + 2*i), int'(ov[i]), int'(eov));
                chki($sformatf("nk%0d_in_ready", 4 + 2*i), int'(irdy[i]), int'(!pend[i]));
                chki($sformatf("nk%0d_busy", 4 + 2*i), int'(bsy[i]), int'(pend[i]));
                chk($sformatf("nk%0d_out_state", 4 + 2*i), ost[i], eov ? exp_ct[i] : last_ct[i]);
            end
        end
    end

    task automatic wait_ov(input int i, input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (ov[i]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic rand_in(input int i);
        for (int j = 0; j < 60; j++) wv[i][32*j +: 32] = $urandom();
        ist[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic run_block(input int i, input logic [127:0] pt, input logic [127:0] lit,
                             input string tag);
        logic [1919:0] ks;
        int            lat;
        ks = key_expand(fips_key(4 + 2*i), 4 + 2*i);
        chk({tag, "_model"}, aes_model(pt, ks, nr_i(i)), lit);
        ist[i] = pt;
        wv[i]  = ks;
        ord[i] = 1'b1;
        iv[i]  = 1'b1;
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        wait_ov(i, 40, lat);
        chki({tag, "_latency"}, lat, nr_i(i));
        chk({tag, "_ct"}, ost[i], lit);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1919:0] ks;
        logic [7:0]    inv;
        int            lat, x0, acc, last_acc;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ ((inv << 1) | (inv >> 7)) ^ ((inv << 2) | (inv >> 6))
                        ^ ((inv << 3) | (inv >> 5)) ^ ((inv << 4) | (inv >> 4)) ^ 8'h63;
        end
        chki("sbox_53", int'(sb[8'h53]), 'hed);
        chki("sbox_00", int'(sb[8'h00]), 'h63);
        ks = key_expand(fips_key(4), 4);
        chk("ks128_round10", ks[1407:1280], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        rst = 1'b1;
        iv  = 3'b000;
        ord = 3'b111;
        for (int i = 0; i < 3; i++) begin
            ist[i] = '0;
            wv[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chki($sformatf("reset_in_ready_%0d", i), int'(irdy[i]), 1);
            chki($sformatf("reset_out_valid_%0d", i), int'(ov[i]), 0);
            chki($sformatf("reset_busy_%0d", i), int'(bsy[i]), 0);
            chk($sformatf("reset_out_state_%0d", i), ost[i], 128'h0);
        end
        @(posedge clk);
        #1;

        run_block(0, PT, CT128, "nk4");
        run_block(1, PT, CT192, "nk6");
        run_block(2, PT, CT256, "nk8");

        // Backpressure with w and in_state scrambled after accept.
        ist[0] = PT;
        wv[0]  = key_expand(fips_key(4), 4);
        ord[0] = 1'b0;
        iv[0]  = 1'b1;
        @(posedge clk);
        #1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            rand_in(0);
            @(posedge clk);
            #1;
            if (ov[0]) begin
                lat = n;
                break;
            end
        end
        chki("bp_latency", lat, 10);
        x0 = xfers[0];
        repeat (20) begin
            rand_in(0);
            @(posedge clk);
            #1;
            chki("bp_hold_valid", int'(ov[0]), 1);
            chk("bp_hold_ct", ost[0], CT128);
        end
        chki("bp_no_transfer", xfers[0], x0);
        iv[0]  = 1'b0;
        ord[0] = 1'b1;
        @(posedge clk);
        #1;
        chki("bp_one_transfer", xfers[0], x0 + 1);
        chki("bp_valid_drop", int'(ov[0]), 0);
        chki("bp_in_ready", int'(irdy[0]), 1);

        // Reset while round 5 is pending.
        ist[0] = PT;
        wv[0]  = key_expand(fips_key(4), 4);
        iv[0]  = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chki("rst_mid_in_ready", int'(irdy[0]), 1);
        chki("rst_mid_out_valid", int'(ov[0]), 0);
        chki("rst_mid_busy", int'(bsy[0]), 0);
        repeat (12) @(posedge clk);
        #1;
        chki("rst_mid_no_output", int'(ov[0]), 0);
        run_block(0, PT, CT128, "post_rst");

        // Back-to-back with in_valid and out_ready tied high.
        x0       = xfers[0];
        acc      = 0;
        last_acc = 0;
        ist[0]   = PT;
        wv[0]    = key_expand(fips_key(4), 4);
        ord[0]   = 1'b1;
        iv[0]    = 1'b1;
        for (int n = 0; n < 100 && acc < 3; n++) begin
            if (irdy[0]) begin
                @(posedge clk);
                #1;
                acc++;
                if (acc > 1) chki("b2b_spacing", edge_cnt - last_acc, 12);
                last_acc = edge_cnt;
                if (acc < 3) begin
                    ist[0] = PT ^ {4{32'(acc) * 32'h9e3779b9}};
                    wv[0]  = key_expand(fips_key(4) ^ {8'(acc * 37), 248'h0}, 4);
                end else begin
                    iv[0] = 1'b0;
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chki("b2b_accepts", acc, 3);
        wait_ov(0, 40, lat);
        chki("b2b_last_latency", lat, 10);
        @(posedge clk);
        #1;
        chki("b2b_transfers", xfers[0] - x0, 3);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
